// File: rtl/cache_controller_burst.sv
// rtl/cache_controller_burst.sv - N-way, multi-beat cache controller FSM with round-robin victim
// Optional hit/miss statistics counters enabled by defining CACHE_STATS_EN.
module cache_controller_burst #(
    parameter  int WAYS  = 4,
    parameter  int BEATS = 4,
    parameter  int CNT_W = 16,
    localparam int WW    = (WAYS  > 1) ? $clog2(WAYS)  : 1,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_type,
    output logic            req_ready,
    input  logic            hit,
    input  logic [WW-1:0]   hit_way,
    input  logic [WAYS-1:0] dirty_vec,
    input  logic            ready_mem,
    output logic            read_en_mem,
    output logic            write_en_mem,
    output logic [BW-1:0]   beat_idx,
    output logic [WW-1:0]   victim_way,
    output logic [WW-1:0]   sel_way,
    output logic            read_en_cache,
    output logic            write_en_cache,
    output logic            write_en,
    output logic            refill,
`ifdef CACHE_STATS_EN
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
`endif
    output logic            done_cache
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_COMPARE    = 2'd1;
    localparam logic [1:0] S_WRITE_BACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE   = 2'd3;

    localparam logic [WW-1:0] LAST_WAY  = WW'(WAYS - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [1:0]    r_state;
    logic [BW-1:0] r_beat;
    logic [WW-1:0] r_victim;
    logic          r_type;
    logic          w_last_beat;

    assign w_last_beat = ready_mem && (r_beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_victim <= '0;
            r_type   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_type  <= req_type;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (hit)
                        r_state <= S_IDLE;
                    else if (dirty_vec[r_victim])
                        r_state <= S_WRITE_BACK;
                    else
                        r_state <= S_ALLOCATE;
                end
                S_WRITE_BACK: begin
                    if (w_last_beat) begin
                        r_beat  <= '0;
                        r_state <= S_ALLOCATE;
                    end else if (ready_mem) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_ALLOCATE: begin
                    // Victim advances only once the refilled line is complete.
                    if (w_last_beat) begin
                        r_beat   <= '0;
                        r_victim <= (r_victim == LAST_WAY) ? '0 : r_victim + 1'b1;
                        r_state  <= S_COMPARE;
                    end else if (ready_mem) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // r_first marks the first COMPARE of a request so the post-refill compare is not counted.
    logic r_first;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (r_state == S_IDLE && req_valid)
                r_first <= 1'b1;
            else if (r_state == S_COMPARE)
                r_first <= 1'b0;
            if (r_state == S_COMPARE && r_first) begin
                if (hit && hit_count != '1)
                    hit_count <= hit_count + 1'b1;
                else if (!hit && miss_count != '1)
                    miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

    assign beat_idx   = r_beat;
    assign victim_way = r_victim;
    assign sel_way    = (r_state == S_COMPARE) ? hit_way : r_victim;
    assign req_ready  = (r_state == S_IDLE);

    always_comb begin
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        write_en       = 1'b0;
        refill         = 1'b0;
        done_cache     = 1'b0;
        case (r_state)
            S_COMPARE: begin
                if (hit) begin
                    read_en_cache  = ~r_type;
                    write_en_cache = r_type;
                    write_en       = r_type;
                    done_cache     = 1'b1;
                end
            end
            S_WRITE_BACK: begin
                write_en_mem  = 1'b1;
                read_en_cache = 1'b1;
            end
            S_ALLOCATE: begin
                read_en_mem    = 1'b1;
                refill         = ready_mem;
                write_en_cache = ready_mem;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller_burst.sv
// tb/tb_cache_controller_burst.sv - directed self-checking bench for cache_controller_burst
module tb_cache_controller_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_type = 1'b0;
    logic       req_ready;
    logic       hit = 1'b0;
    logic [1:0] hit_way = 2'd0;
    logic [3:0] dirty_vec = 4'd0;
    logic       ready_mem = 1'b0;
    logic       read_en_mem, write_en_mem;
    logic [1:0] beat_idx, victim_way, sel_way;
    logic       read_en_cache, write_en_cache, write_en, refill, done_cache;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int n_total = 0;
    int n_bad   = 0;

    cache_controller_burst #(.WAYS(4), .BEATS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready),
        .hit(hit), .hit_way(hit_way), .dirty_vec(dirty_vec), .ready_mem(ready_mem),
        .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
        .beat_idx(beat_idx), .victim_way(victim_way), .sel_way(sel_way),
        .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
        .write_en(write_en), .refill(refill),
`ifdef CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .done_cache(done_cache)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic t);
        req_valid = 1'b1;
        req_type  = t;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic clean_miss(input logic [1:0] exp_victim);
        accept(1'b0);
        hit = 1'b0;
        dirty_vec = 4'd0;
        #1;
        check("miss_victim", victim_way, exp_victim);
        check("miss_no_done", done_cache, 0);
        tick();
        ready_mem = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ready_mem = 1'b0;
        hit = 1'b1;
        #1;
        check("miss_done", done_cache, 1);
        tick();
        hit = 1'b0;
    endtask

    initial begin
        int pat[6] = '{1, 0, 1, 1, 0, 1};
        int nref;
        int ncyc;
        int nwb;
        int nrf;
        bit seen;

        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_ready", req_ready, 1);
        check("rst_beat", beat_idx, 0);
        check("rst_victim", victim_way, 0);
        check("rst_done", done_cache, 0);
        check("rst_memrd", read_en_mem, 0);

        // read hit
        req_valid = 1'b1; req_type = 1'b0;
        #1;
        check("rh_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        hit = 1'b1; hit_way = 2'd1;
        #1;
        check("rh_rd", read_en_cache, 1);
        check("rh_done", done_cache, 1);
        check("rh_wr", write_en_cache, 0);
        check("rh_sel", sel_way, 1);
        check("rh_busy", req_ready, 0);
        tick();
        hit = 1'b0;
        #1;
        check("rh_idle", req_ready, 1);
        check("rh_done_pulse", done_cache, 0);

        // write hit
        accept(1'b1);
        hit = 1'b1; hit_way = 2'd2;
        #1;
        check("wh_wr", write_en_cache, 1);
        check("wh_dirty", write_en, 1);
        check("wh_sel", sel_way, 2);
        check("wh_done", done_cache, 1);
        check("wh_rd", read_en_cache, 0);
        tick();
        hit = 1'b0;
        #1;
        check("wh_done_pulse", done_cache, 0);

        // clean miss with stalled memory
        accept(1'b0);
        hit = 1'b0; dirty_vec = 4'b0000;
        #1;
        check("cm_victim", victim_way, 0);
        check("cm_nostrobe", read_en_cache | write_en_cache | read_en_mem | write_en_mem, 0);
        tick();
        nref = 0;
        for (int i = 0; i < 6; i++) begin
            ready_mem = pat[i][0];
            #1;
            check("cm_memrd", read_en_mem, 1);
            check("cm_refill", refill, pat[i]);
            check("cm_nodone", done_cache, 0);
            if (pat[i] == 1) begin
                check("cm_beat", beat_idx, nref);
                nref++;
            end
            tick();
        end
        ready_mem = 1'b0;
        hit = 1'b1;
        #1;
        check("cm_refills", nref, 4);
        check("cm_done", done_cache, 1);
        check("cm_memoff", read_en_mem, 0);
        check("cm_victim_next", victim_way, 1);
        tick();
        hit = 1'b0;

        // async reset in IDLE restores victim pointer to 0
        #1 rst = 1'b0;
        #1 check("rst2_victim", victim_way, 0);
        rst = 1'b1;
        tick();

        // dirty miss, memory always ready
        dirty_vec = 4'b0001;
        ready_mem = 1'b1;
        accept(1'b0);
        hit = 1'b0;
        ncyc = 1; nwb = 0; nrf = 0; seen = 0;
        #1;
        check("dm_victim", victim_way, 0);
        tick();
        hit = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            ncyc++;
            #1;
            if (write_en_mem) nwb++;
            if (refill) nrf++;
            if (done_cache) begin
                seen = 1;
                check("dm_done_excl", read_en_mem | write_en_mem, 0);
            end else begin
                tick();
            end
        end
        check("dm_seen", seen, 1);
        check("dm_cycles", ncyc, 10);
        check("dm_wb_beats", nwb, 4);
        check("dm_rf_beats", nrf, 4);
        tick();
        hit = 1'b0; dirty_vec = 4'd0; ready_mem = 1'b0;

        // victim wrap after four misses
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        for (int v = 0; v < 4; v++) clean_miss(v[1:0]);
        check("wrap_victim", victim_way, 0);

        // reset during ALLOCATE beat 2
        clean_miss(2'd0);
        accept(1'b0);
        hit = 1'b0;
        #1;
        check("mr_victim", victim_way, 1);
        tick();
        ready_mem = 1'b1;
        tick();
        tick();
        #1;
        check("mr_beat2", beat_idx, 2);
        rst = 1'b0;
        #1;
        check("mr_ready", req_ready, 1);
        check("mr_beat", beat_idx, 0);
        check("mr_victim0", victim_way, 0);
        check("mr_done", done_cache, 0);
        check("mr_memrd", read_en_mem, 0);
        check("mr_refill", refill, 0);
        ready_mem = 1'b0;
        tick();
        rst = 1'b1;
        tick();

`ifdef CACHE_STATS_EN
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            accept(1'b0);
            hit = 1'b1;
            tick();
            hit = 1'b0;
        end
        clean_miss(2'd0);
        clean_miss(2'd1);
        check("st_hits", hit_count, 3);
        check("st_miss", miss_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_controller_burst.md
Name: cache_controller_burst

Overview:
- Parametrised successor to the single-way cache controller FSM: N-way set-associative, multi-beat line transfers.
- Round-robin victim selection.
- Sits between the core request port and the tag/data arrays plus the memory interface.
- Drives cache and memory strobes; tag comparison and data movement stay outside the block.

Parameters:
- WAYS, 4, associativity; power of 2, >=1.
- BEATS, 4, memory beats per cache line; power of 2, >=1.
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_type  in  1  0=read, 1=write.
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
- hit  in  1  tag match for the latched request (valid in COMPARE).
- hit_way  in  WW  way that hit; WW = max(1, clog2(WAYS)).
- dirty_vec  in  WAYS  dirty bits of the addressed set.
- ready_mem  in  1  memory accepts/returns one beat this cycle.
- read_en_mem  out  1  memory read request (ALLOCATE).
- write_en_mem  out  1  memory write request (WRITE_BACK).
- beat_idx  out  BW  current beat; BW = max(1, clog2(BEATS)).
- victim_way  out  WW  way selected for eviction/refill.
- sel_way  out  WW  way addressed by cache strobes: hit_way in COMPARE, victim_way otherwise.
- read_en_cache  out  1  cache data read.
- write_en_cache  out  1  cache data write.
- write_en  out  1  set dirty bit of sel_way (write hit).
- refill  out  1  write returned memory beat into cache line.
- done_cache  out  1  request completed, one-cycle pulse.

Behaviour:
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- Outputs are combinational decodes of state, hit, dirty_vec and ready_mem. beat_idx, the victim pointer and the latched req_type are registered.
- Reset (rst=0, async): state=IDLE, beat_idx=0, victim pointer=0, latched type=0. All strobes 0; req_ready=1 after release.
- IDLE: req_ready=1. On req_valid, latch req_type and move to COMPARE next edge. No other outputs.
- COMPARE, hit=1, read: read_en_cache=1, done_cache=1, return to IDLE.
  - Latency: done one cycle after acceptance.
- COMPARE, hit=1, write: write_en_cache=1, write_en=1, done_cache=1, return to IDLE.
- COMPARE, hit=0: go to WRITE_BACK if dirty_vec[victim_way]=1, else ALLOCATE. No strobes.
- WRITE_BACK:
  - write_en_mem=1 and read_en_cache=1 each cycle.
  - beat_idx increments only on cycles with ready_mem=1.
  - On the beat with beat_idx=BEATS-1 and ready_mem=1: beat_idx wraps to 0, go to ALLOCATE.
- ALLOCATE:
  - read_en_mem=1.
  - refill=ready_mem and write_en_cache=ready_mem for the current beat_idx.
  - On the last beat: beat_idx->0, victim pointer advances (WAYS-1 wraps to 0), return to COMPARE.
  - COMPARE re-evaluates; the tag array must then report hit.
- Stalls: ready_mem=0 holds state and beat_idx with request strobes held high. No done_cache until completion.
- req_valid while not IDLE: ignored (req_ready=0), no latch.
- hit/dirty_vec outside COMPARE: ignored.
- WAYS=1: victim pointer constant 0. BEATS=1: single-beat transfers, beat_idx constant 0.
- Reset asserted mid-transfer: immediate return to IDLE, beat count discarded, no done_cache, strobes drop asynchronously.
- done_cache never asserts in the same cycle as read_en_mem or write_en_mem.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count and miss_count (CNT_W each).
  - Counters are sampled on the first COMPARE cycle of each request only; the post-refill re-compare is not counted.
  - hit_count increments on a hit; miss_count increments on a miss.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Read hit: req_valid=1, req_type=0, hit=1 at accept+1 -> read_en_cache=1, done_cache=1 in COMPARE; IDLE next cycle; req_ready=1.
- Write hit: req_type=1, hit=1, hit_way=2 -> write_en_cache=1, write_en=1, sel_way=2, done_cache=1 for exactly one cycle.
- Clean read miss, BEATS=4, ready_mem toggled 1,0,1,1,0,1:
  - read_en_mem high throughout; refill pulses exactly 4 times with beat_idx 0,1,2,3.
  - Back to COMPARE; hit=1 -> done_cache=1; victim_way 0->1.
- Dirty miss with dirty_vec=4'b0001, victim 0 -> 4 beats with write_en_mem=1, then 4 refill beats, then done.
  - Total cycles from accept = 1+4+4+1 with ready_mem tied to 1.
- Wrap and reset:
  - 4 consecutive misses -> victim_way 0,1,2,3,0.
  - rst=0 during ALLOCATE beat 2 -> IDLE immediately, beat_idx=0, victim_way=0, no done_cache.
- CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2.
  - With CNT_W=2 and 5 hits -> hit_count saturates at 3.
